// File: rtl/and_or_stim_checker_pkg.sv
// Shared definitions for the and-or gate stimulus checker: FSM state
// encoding, vector/error limits and the reference model of the gate stage.
package and_or_stim_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_VEC = 3'b111;
  localparam logic [3:0] ERR_MAX  = 4'd15;

  // Reference responses {D_exp, E_exp} for a stimulus vector {A,B,C}.
  function automatic logic [1:0] expectedResp(input logic [2:0] abc);
    expectedResp = {(abc[2] & abc[1]) | ~abc[0], ~abc[0]};
  endfunction

endpackage

// File: rtl/and_or_stim_checker_sync2.sv
// Two-flop synchronizer bringing one asynchronous gate response into the
// checker clock domain.
module sync2 (
  input  logic i_clock,
  input  logic i_reset_b,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge i_clock or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/and_or_stim_checker.sv
// Walks {A,B,C} through all eight vectors, lets the downstream gate stage
// settle, and compares its synchronized responses against the reference.
module and_or_stim_checker
  import and_or_stim_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       D,
  input  logic       E,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_seen,
  output logic [2:0] fail_vec
);

  // SETTLE exits when the counter reaches this value, giving SETTLE_CYCLES
  // cycles in SETTLE; the counter is cleared on entry.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_vec;
  logic [3:0] r_settleCnt;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_errCount;
  logic       r_failSeen;
  logic [2:0] r_failVec;

  logic       w_dSync;
  logic       w_eSync;
  logic [1:0] w_expResp;
  logic       w_mismatch;

  sync2 u_syncD (
    .i_clock   (clock),
    .i_reset_b (reset_b),
    .i_async   (D),
    .o_sync    (w_dSync)
  );

  sync2 u_syncE (
    .i_clock   (clock),
    .i_reset_b (reset_b),
    .i_async   (E),
    .o_sync    (w_eSync)
  );

  assign w_expResp  = expectedResp(r_vec);
  assign w_mismatch = ({w_dSync, w_eSync} != w_expResp);

  // Run sequencer: start a run, settle each vector, check it, advance.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= IDLE;
      r_vec       <= 3'd0;
      r_settleCnt <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_errCount  <= 4'd0;
      r_failSeen  <= 1'b0;
      r_failVec   <= 3'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_vec       <= 3'd0;
            r_settleCnt <= 4'd0;
            r_errCount  <= 4'd0;
            r_failSeen  <= 1'b0;
            r_failVec   <= 3'd0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_settleCnt == SETTLE_LAST) begin
            r_state <= CHECK;
          end else begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_errCount != ERR_MAX) begin
              r_errCount <= r_errCount + 4'd1;
            end
            if (!r_failSeen) begin
              r_failSeen <= 1'b1;
              r_failVec  <= r_vec;
            end
          end
          if (r_vec == LAST_VEC) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_vec       <= r_vec + 3'd1;
            r_settleCnt <= 4'd0;
            r_state     <= SETTLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign A         = r_vec[2];
  assign B         = r_vec[1];
  assign C         = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_errCount;
  assign fail_seen = r_failSeen;
  assign fail_vec  = r_failVec;
  assign pass      = r_done && (r_errCount == 4'd0);

endmodule

// File: tb/tb_and_or_stim_checker.sv
// Bench for and_or_stim_checker: a behavioural gate stage with selectable
// faults feeds D/E back, and each run's final results are scoreboarded.
`timescale 1ns/1ps
module tb_and_or_stim_checker;

  localparam int SETTLE   = 4;
  localparam int RUN_LEN  = 8 * (SETTLE + 1);

  logic       clock;
  logic       reset_b;
  logic       start;
  logic       A, B, C;
  logic       D, E;
  logic       busy, done, pass, fail_seen;
  logic [3:0] err_count;
  logic [2:0] fail_vec;

  // 0 correct, 1 D stuck-0, 2 E inverted, 3 D stuck-1, 4 E stuck-0
  int faultMode;

  int checks;
  int failures;

  typedef struct {
    int mode;
    int expErr;
    int expFailSeen;
    int expFailVec;
    int expPass;
  } runExp_t;

  runExp_t runTable[5];
  runExp_t expQ[$];

  and_or_stim_checker #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .start     (start),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .E         (E),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_seen (fail_seen),
    .fail_vec  (fail_vec)
  );

  // Downstream gate stage with a little propagation delay and planted faults.
  assign #1 D = (faultMode == 1) ? 1'b0 :
                (faultMode == 3) ? 1'b1 : ((A & B) | ~C);
  assign #2 E = (faultMode == 2) ? C :
                (faultMode == 4) ? 1'b0 : ~C;

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_abc"}, {A, B, C}, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_err"}, err_count, 0);
    checkOutput({tag, "_fail_seen"}, fail_seen, 0);
    checkOutput({tag, "_fail_vec"}, fail_vec, 0);
  endtask

  // Drive one full run from an idle/done negedge; optional start re-pulse
  // mid-run, and optional start left high at the end to chain a new run.
  task automatic applyStimulus(input int idx, input int restartAt, input bit keepStart);
    bit popped;
    runExp_t exp;
    popped    = 1'b0;
    faultMode = runTable[idx].mode;
    expQ.push_back(runTable[idx]);
    start = 1'b1;
    @(posedge clock);
    for (int m = 0; m <= RUN_LEN; m++) begin
      @(negedge clock);
      checkOutput($sformatf("run%0d_abc_m%0d", idx, m), {A, B, C},
                  (m < RUN_LEN) ? m / (SETTLE + 1) : 7);
      checkOutput($sformatf("run%0d_busy_m%0d", idx, m), busy, (m < RUN_LEN) ? 1 : 0);
      checkOutput($sformatf("run%0d_done_m%0d", idx, m), done, (m >= RUN_LEN) ? 1 : 0);
      if (m == 0) begin
        checkOutput($sformatf("run%0d_err_cleared", idx), err_count, 0);
        checkOutput($sformatf("run%0d_fail_seen_cleared", idx), fail_seen, 0);
      end
      if (m < RUN_LEN) begin
        checkOutput($sformatf("run%0d_pass_low_m%0d", idx, m), pass, 0);
      end
      if (done && !popped) begin
        popped = 1'b1;
        if (expQ.size() == 0) begin
          checkOutput($sformatf("run%0d_scoreboard_empty", idx), 1, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput($sformatf("run%0d_err_count", idx), err_count, exp.expErr);
          checkOutput($sformatf("run%0d_fail_seen", idx), fail_seen, exp.expFailSeen);
          checkOutput($sformatf("run%0d_fail_vec", idx), fail_vec, exp.expFailVec);
          checkOutput($sformatf("run%0d_pass", idx), pass, exp.expPass);
        end
      end
      if (!keepStart) begin
        if (m == restartAt) start = 1'b1;
        else if (m == restartAt + 1 || m == 0) start = 1'b0;
      end
    end
    if (!popped) begin
      checkOutput($sformatf("run%0d_done_seen", idx), 0, 1);
      if (expQ.size() != 0) exp = expQ.pop_front();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    faultMode = 0;
    runTable[0] = '{mode: 0, expErr: 0, expFailSeen: 0, expFailVec: 0, expPass: 1};
    runTable[1] = '{mode: 1, expErr: 5, expFailSeen: 1, expFailVec: 0, expPass: 0};
    runTable[2] = '{mode: 2, expErr: 8, expFailSeen: 1, expFailVec: 0, expPass: 0};
    runTable[3] = '{mode: 3, expErr: 3, expFailSeen: 1, expFailVec: 1, expPass: 0};
    runTable[4] = '{mode: 4, expErr: 4, expFailSeen: 1, expFailVec: 0, expPass: 0};

    reset_b = 1'b0;
    start   = 1'b0;
    #1;
    checkAllZero("reset");
    repeat (2) @(negedge clock);
    reset_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput($sformatf("idle_busy_%0d", i), busy, 0);
      checkOutput($sformatf("idle_abc_%0d", i), {A, B, C}, 0);
    end

    // Table runs; the first one also re-pulses start while busy.
    for (int idx = 0; idx < 5; idx++) begin
      applyStimulus(idx, (idx == 0) ? 12 : -1, 1'b0);
      for (int h = 0; h < 2; h++) begin
        @(negedge clock);
        checkOutput($sformatf("hold%0d_done_%0d", idx, h), done, 1);
        checkOutput($sformatf("hold%0d_abc_%0d", idx, h), {A, B, C}, 7);
      end
    end

    // Reset asserted while vector 011 is applied aborts the run.
    faultMode = 2;
    start = 1'b1;
    @(posedge clock);
    for (int m = 0; m <= 17; m++) begin
      @(negedge clock);
      if (m == 0) start = 1'b0;
    end
    checkOutput("abort_pre_abc", {A, B, C}, 3);
    checkOutput("abort_pre_err", err_count, 3);
    checkOutput("abort_pre_fail_seen", fail_seen, 1);
    reset_b = 1'b0;
    #1;
    checkAllZero("abort");
    repeat (2) @(negedge clock);
    reset_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput($sformatf("post_abort_done_%0d", i), done, 0);
      checkOutput($sformatf("post_abort_busy_%0d", i), busy, 0);
    end
    applyStimulus(0, -1, 1'b0);

    // start held high through a failing run and past done chains a clean run.
    @(negedge clock);
    applyStimulus(1, -1, 1'b1);
    applyStimulus(0, -1, 1'b0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
